// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: divider FSM state type, datapath width and
// the DIV/DIVU function codes used by the decode stage.
package mips_defs_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Divider FSM encoding; kept as plain constants so legacy tools accept it.
    typedef logic [1:0] div_state_t;
    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t BUSY = 2'd1;
    localparam div_state_t DONE = 2'd2;

    // R-type function field values for the decoder's isDiv flag.
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider, purely combinational.
// The partial remainder is one bit wider than the divisor so the shifted value
// never overflows; the trial subtract gets one further bit for its sign.
module div_step
    import mips_defs_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Shift in the next dividend bit, try the subtract, keep it if non-negative.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Iterative restoring divider with its control FSM for the MIPS EX stage.
// Handles DIV/DIVU: stalls the pipeline while iterating, then presents the
// remainder (HI) and quotient (LO) with a one-cycle result_valid strobe.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and |opa| < |opb|
// finish straight from IDLE without iterating.
module div_sequencer
    import mips_defs_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall_div,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // |divisor|
    logic [WIDTH-1:0] orig_a_q, orig_a_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    // Operand magnitudes; only signed divides take the absolute value.
    always_comb begin
        abs_a = (signed_div && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
        abs_b = (signed_div && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
    end

`ifdef DIV_EARLY_OUT_EN
    logic early_out;

    // Results known without iterating: divide by zero or dividend below divisor.
    always_comb begin
        early_out = (opb == '0) || (abs_a < abs_b);
    end
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Final step's outputs, used when leaving BUSY.
    always_comb begin
        quot_final = {dvd_q[WIDTH-2:0], step_q};
        rem_final  = step_rem[WIDTH-1:0];
    end

    // FSM and datapath next-state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        orig_a_d = orig_a_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    dvd_d    = abs_a;
                    dvs_d    = abs_b;
                    orig_a_d = opa;
                    qneg_d   = signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    rneg_d   = signed_div && opa[WIDTH-1];
                    dz_d     = (opb == '0);
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
`ifdef DIV_EARLY_OUT_EN
                    if (early_out) begin
                        // Dividend is the remainder as-is (already carries its sign).
                        hi_d    = opa;
                        lo_d    = (opb == '0) ? '1 : '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        if (dz_q) begin
                            hi_d = orig_a_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rneg_q ? (~rem_final + 1'b1) : rem_final;
                            lo_d = qneg_q ? (~quot_final + 1'b1) : quot_final;
                        end
                    end
                end
            end
            DONE: begin
                // start is still the same instruction here, so it is ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            orig_a_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            orig_a_q <= orig_a_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Combinational handshake outputs; cancel wins over everything.
    always_comb begin
        stall_div    = (((state_q == IDLE) && start) || (state_q == BUSY)) && !cancel;
        result_valid = (state_q == DONE) && !cancel;
        hi_out       = hi_q;
        lo_out       = lo_q;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with an arithmetic reference model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        stall_div;
    logic        result_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the current cycle, maintained by the stimulus.
    logic        exp_stall = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_hi    = '0;
    logic [31:0] exp_lo    = '0;
    int          stall_cycles = 0;
    int          valid_cycles = 0;

    div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .cancel       (cancel),
        .stall_div    (stall_div),
        .result_valid (result_valid),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics in plain arithmetic.
    function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
        end
    endfunction

    function automatic longint mag(input bit sg, input logic [31:0] v);
        longint x;
        x = sg ? longint'($signed(v)) : longint'(v);
        return (x < 0) ? -x : x;
    endfunction

    // Cycle index of the result_valid cycle, counted from the start cycle.
    function automatic int done_cycle(input bit sg, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || mag(sg, a) < mag(sg, b)) return 1;
`endif
        return 33;
    endfunction

    // Every cycle, mid-cycle: DUT outputs against the expected timeline.
    always @(negedge clk) begin
        if (!rst) begin
            chk("stall_div", {31'd0, stall_div}, {31'd0, exp_stall});
            chk("result_valid", {31'd0, result_valid}, {31'd0, exp_valid});
            chk("hi_out", hi_out, exp_hi);
            chk("lo_out", lo_out, exp_lo);
            if (stall_div) stall_cycles++;
            if (result_valid) valid_cycles++;
        end
    end

    // Issue one divide starting in the current cycle; start held while in EX.
    // cancel_cyc / rst_cyc < 0 means not used.
    task automatic div_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_cyc, input int rst_cyc);
        int          last;
        logic [31:0] q;
        logic [31:0] r;
        last = done_cycle(sg, a, b);
        model(sg, a, b, q, r);
        stall_cycles = 0;
        valid_cycles = 0;
        for (int c = 0; c <= last; c++) begin
            start      = 1'b1;
            signed_div = sg;
            opa        = a;
            opb        = b;
            cancel     = (c == cancel_cyc);
            if (c == cancel_cyc) begin
                exp_stall = 1'b0;
                exp_valid = 1'b0;
                @(posedge clk);
                #1;
                start  = 1'b0;
                cancel = 1'b0;
                return;
            end
            if (c == rst_cyc) begin
                #1;
                start = 1'b0;
                rst   = 1'b1;
                #1;
                chk("rst_stall", {31'd0, stall_div}, 32'd0);
                chk("rst_valid", {31'd0, result_valid}, 32'd0);
                chk("rst_hi", hi_out, 32'd0);
                chk("rst_lo", lo_out, 32'd0);
                exp_stall = 1'b0;
                exp_valid = 1'b0;
                exp_hi    = '0;
                exp_lo    = '0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            exp_stall = (c < last);
            exp_valid = (c == last);
            if (c == last) begin
                exp_hi = r;
                exp_lo = q;
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        chk("stall_cycles", stall_cycles, last);
        chk("valid_cycles", valid_cycles, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = '0;
        opb        = '0;
        cancel     = 1'b0;
        #1;
        chk("reset_stall", {31'd0, stall_div}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);

        // Pin the model against hand-computed values.
        model(1'b0, 32'd100, 32'd7, mq, mr);
        chk("model_divu_q", mq, 32'd14);
        chk("model_divu_r", mr, 32'd2);
        model(1'b1, 32'hFFFF_FFF9, 32'd2, mq, mr);
        chk("model_div_q", mq, 32'hFFFF_FFFD);
        chk("model_div_r", mr, 32'hFFFF_FFFF);
        model(1'b1, 32'd100, 32'hFFFF_FFF9, mq, mr);
        chk("model_div_negb_q", mq, 32'hFFFF_FFF2);
        chk("model_div_negb_r", mr, 32'd2);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        div_op(1'b0, 32'd100, 32'd7, -1, -1);
        chk("divu_100_7_lo", lo_out, 32'd14);
        chk("divu_100_7_hi", hi_out, 32'd2);
        idle(2);

        div_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        chk("div_m7_2_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", hi_out, 32'hFFFF_FFFF);
        idle(1);

        div_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        chk("div_ovf_lo", lo_out, 32'h8000_0000);
        chk("div_ovf_hi", hi_out, 32'd0);
        idle(1);

        div_op(1'b1, 32'd100, 32'hFFFF_FFF9, -1, -1);
        div_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, -1);
        idle(1);

        div_op(1'b0, 32'd5, 32'd0, -1, -1);
        chk("divu_5_0_lo", lo_out, 32'hFFFF_FFFF);
        chk("divu_5_0_hi", hi_out, 32'd5);
        idle(1);
        div_op(1'b1, 32'd5, 32'd0, -1, -1);
        chk("div_5_0_lo", lo_out, 32'hFFFF_FFFF);
        chk("div_5_0_hi", hi_out, 32'd5);
        idle(1);

        // Cancel in cycle 10: no result, outputs keep previous values.
        div_op(1'b0, 32'd1000, 32'd3, 10, -1);
        idle(40);
        chk("cancel_hold_lo", lo_out, 32'hFFFF_FFFF);
        chk("cancel_hold_hi", hi_out, 32'd5);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        div_op(1'b0, 32'h0000_1234, 32'h10, -1, -1);
        div_op(1'b0, 32'd9, 32'd3, -1, -1);
        chk("b2b_lo", lo_out, 32'd3);
        chk("b2b_hi", hi_out, 32'd0);
        idle(3);

        // Asynchronous reset in cycle 15 of a divide.
        div_op(1'b0, 32'hDEAD_BEEF, 32'h77, -1, 15);
        idle(40);

        div_op(1'b0, 32'd3, 32'd8, -1, -1);
        chk("divu_3_8_lo", lo_out, 32'd0);
        chk("divu_3_8_hi", hi_out, 32'd3);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
